// File: rtl/median_stream_engine_if.sv
// Stream bundle for the median engine: NCH input lanes popped together and
// one output lane, each with valid/ready handshaking.
interface median_stream_engine_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 3
);
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [NCH*WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/median_stream_engine.sv
// Streaming median engine: pops one word from every input lane at once,
// registers their median and repeats for a run-time iteration count.
module median_stream_engine #(
    parameter int WIDTH  = 32,
    parameter int NCH    = 3,
    parameter int CW     = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CW-1:0]          iters,
    median_stream_engine_if.slave  strm,
    output logic [CW-1:0]          count,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [3:0] MID = 4'((NCH - 1) / 2);

    state_t            state_q;
    logic [CW-1:0]     target_q;
    logic [CW-1:0]     count_q;
    logic              outValid_q;
    logic [WIDTH-1:0]  outData_q;
    logic              busy_q;
    logic              done_q;

    logic [WIDTH-1:0]  word [NCH];
    logic [WIDTH-1:0]  median_d;
    logic [3:0]        rank;
    logic              accept;

    function automatic logic lessThan(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign word[k] = strm.in_data[k*WIDTH +: WIDTH];
    end

    // Equal words are ranked by lane index, so exactly one lane lands on the middle rank.
    always_comb begin
        median_d = '0;
        rank     = '0;
        for (int i = 0; i < NCH; i++) begin
            rank = '0;
            for (int j = 0; j < NCH; j++) begin
                if (lessThan(word[j], word[i]) || (j < i && word[j] == word[i]))
                    rank = rank + 4'd1;
            end
            if (rank == MID) median_d = word[i];
        end
    end

    assign accept        = (state_q == RUN) && (&strm.in_valid) && (!outValid_q || strm.out_ready);
    assign strm.in_ready = {NCH{accept}};
    assign strm.out_valid = outValid_q;
    assign strm.out_data  = outData_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        target_q <= iters;
                        count_q  <= '0;
                        if (iters == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (accept && count_q == target_q - 1'b1)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (outValid_q && strm.out_ready) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A pop and a new accept in the same cycle keep out_valid high without a bubble.
            if (accept) begin
                outData_q  <= median_d;
                outValid_q <= 1'b1;
                count_q    <= count_q + 1'b1;
            end else if (outValid_q && strm.out_ready) begin
                outValid_q <= 1'b0;
            end
        end
    end
endmodule
